// File: rtl/mxu_pkg.sv
// Shared constants for the systolic matrix unit: feeder FSM states and phase lengths
// so the feeder, array and result collector agree on cycle counts.
package mxu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } feeder_state_t;

    typedef struct packed {
        logic [15:0] feed;
        logic [15:0] drain;
    } phase_len_t;

    // Skewed feed spans 2*DIM-1 cycles; the last product needs DIM more to settle.
    function automatic phase_len_t phase_lens(input int dim);
        phase_len_t p;
        p.feed  = 16'(2 * dim - 1);
        p.drain = 16'(dim);
        return p;
    endfunction

endpackage

// File: rtl/mxu_skew_lane.sv
// One edge lane of the operand skew: emits vec[t-lane] while that index falls
// inside the vector, otherwise zero.
module mxu_skew_lane #(
    parameter int DIM   = 8,
    parameter int WIDTH = 4,
    parameter int CW    = 4
) (
    input  logic [DIM-1:0][WIDTH-1:0] vec,
    input  logic [CW-1:0]             lane,
    input  logic [CW-1:0]             t,
    input  logic                      feed_valid,
    output logic [WIDTH-1:0]          elem
);

    logic [CW-1:0] k;
    logic          in_win;

    // Unsigned wrap of t-lane is harmless: the t >= lane term rejects it.
    assign k      = t - lane;
    assign in_win = feed_valid && (t >= lane) && (k <= CW'(DIM - 1));

    always_comb begin
        elem = '0;
        for (int e = 0; e < DIM; e++) begin
            if (in_win && (k == CW'(e))) begin
                elem = vec[e];
            end
        end
    end

endmodule

// File: rtl/mxu_operand_feeder.sv
// Operand feeder for the output-stationary systolic array: captures an A/B pair,
// then sequences accumulator clear, diagonally skewed edge feed, drain and done.
module mxu_operand_feeder
    import mxu_pkg::*;
#(
    parameter int DIM   = 8,
    parameter int WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   in_a,
    input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   in_b,
    output logic [DIM-1:0][WIDTH-1:0]            west_out,
    output logic [DIM-1:0][WIDTH-1:0]            north_out,
    output logic                                 feed_valid,
    output logic                                 acc_clear,
    output logic                                 finished
);

    localparam int                CW         = $clog2(2 * DIM);
    localparam phase_len_t        PL         = phase_lens(DIM);
    localparam logic [CW-1:0]     FEED_LAST  = CW'(PL.feed - 16'd1);
    localparam logic [CW-1:0]     DRAIN_LAST = CW'(PL.drain - 16'd1);

    feeder_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0] a_q, b_q;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0] b_col;
    logic accept;

    // The reset pin is active-high despite its name.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
            end
        end
    end

    assign accept = in_valid && (state == IDLE);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        in_ready   = 1'b0;
        feed_valid = 1'b0;
        acc_clear  = 1'b0;
        finished   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CLEAR;
            end
            CLEAR: begin
                acc_clear = 1'b1;
                cnt_nx    = '0;
                state_nx  = FEED;
            end
            FEED: begin
                feed_valid = 1'b1;
                if (cnt == FEED_LAST) begin
                    cnt_nx   = '0;
                    state_nx = DRAIN;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    cnt_nx   = '0;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DONE: begin
                finished = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // North lanes walk down a column of B, so present B transposed.
    always_comb begin
        for (int j = 0; j < DIM; j++) begin
            for (int k = 0; k < DIM; k++) begin
                b_col[j][k] = b_q[k][j];
            end
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        mxu_skew_lane #(.DIM(DIM), .WIDTH(WIDTH), .CW(CW)) u_west (
            .vec        (a_q[i]),
            .lane       (CW'(i)),
            .t          (cnt),
            .feed_valid (feed_valid),
            .elem       (west_out[i])
        );
        mxu_skew_lane #(.DIM(DIM), .WIDTH(WIDTH), .CW(CW)) u_north (
            .vec        (b_col[i]),
            .lane       (CW'(i)),
            .t          (cnt),
            .feed_valid (feed_valid),
            .elem       (north_out[i])
        );
    end

endmodule

// File: tb/tb_mxu_operand_feeder.sv
// Scoreboard bench for the operand feeder: a DIM=2 instance for hand-computed
// vectors and handshake, a DIM=8 instance for windowing and mid-feed reset.
module tb_mxu_operand_feeder;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic rst2, v2, rdy2, fv2, clr2, fin2;
    logic [1:0][1:0][W-1:0] a2, b2;
    logic [1:0][W-1:0]      w2, n2;

    logic rst8, v8, rdy8, fv8, clr8, fin8;
    logic [7:0][7:0][W-1:0] a8, b8;
    logic [7:0][W-1:0]      w8, n8;

    mxu_operand_feeder #(.DIM(2), .WIDTH(W)) u2 (
        .clk(clk), .reset_n(rst2), .in_valid(v2), .in_ready(rdy2),
        .in_a(a2), .in_b(b2), .west_out(w2), .north_out(n2),
        .feed_valid(fv2), .acc_clear(clr2), .finished(fin2)
    );

    mxu_operand_feeder #(.DIM(8), .WIDTH(W)) u8 (
        .clk(clk), .reset_n(rst8), .in_valid(v8), .in_ready(rdy8),
        .in_a(a8), .in_b(b8), .west_out(w8), .north_out(n8),
        .feed_valid(fv8), .acc_clear(clr8), .finished(fin8)
    );

    typedef struct {
        int          cyc;
        logic [31:0] w;
        logic [31:0] n;
    } feed_t;

    feed_t fq2[$], fq8[$];
    int    clrq2[$], clrq8[$], finq2[$], finq8[$];
    feed_t e2, e8;
    feed_t none = '{-1, 32'h0, 32'h0};
    int    bs2 = 1, be2 = 0, bs8 = 1, be8 = 0;   // cycles in which in_ready must be low
    int    ea8[8][8], eb8[8][8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop expectations whenever the DUT presents clear/feed/finished.
    always @(negedge clk) begin
        chk("rdy2", 32'(rdy2), (cyc >= bs2 && cyc <= be2) ? 32'd0 : 32'd1);
        if (clr2) begin
            chk("clr2_cyc", cyc, clrq2.size() != 0 ? clrq2.pop_front() : -1);
            chk("clr2_vs_feed", 32'(fv2), 32'd0);
        end
        if (fin2) chk("fin2_cyc", cyc, finq2.size() != 0 ? finq2.pop_front() : -1);
        if (fv2) begin
            e2 = fq2.size() != 0 ? fq2.pop_front() : none;
            chk("feed2_cyc", cyc, e2.cyc);
            chk("west2", 32'(w2), e2.w);
            chk("north2", 32'(n2), e2.n);
        end else begin
            chk("west2_idle", 32'(w2), 32'd0);
            chk("north2_idle", 32'(n2), 32'd0);
        end
    end

    always @(negedge clk) begin
        chk("rdy8", 32'(rdy8), (cyc >= bs8 && cyc <= be8) ? 32'd0 : 32'd1);
        if (clr8) begin
            chk("clr8_cyc", cyc, clrq8.size() != 0 ? clrq8.pop_front() : -1);
            chk("clr8_vs_feed", 32'(fv8), 32'd0);
        end
        if (fin8) chk("fin8_cyc", cyc, finq8.size() != 0 ? finq8.pop_front() : -1);
        if (fv8) begin
            e8 = fq8.size() != 0 ? fq8.pop_front() : none;
            chk("feed8_cyc", cyc, e8.cyc);
            chk("west8", 32'(w8), e8.w);
            chk("north8", 32'(n8), e8.n);
        end else begin
            chk("west8_idle", 32'(w8), 32'd0);
            chk("north8_idle", 32'(n8), 32'd0);
        end
    end

    // A=[[1,2],[3,4]], B=[[5,6],[7,8]]; lanes packed {lane1,lane0}.
    task automatic push2(input int c0);
        clrq2.push_back(c0);
        fq2.push_back('{c0 + 1, 32'h01, 32'h05});
        fq2.push_back('{c0 + 2, 32'h32, 32'h67});
        fq2.push_back('{c0 + 3, 32'h40, 32'h80});
        finq2.push_back(c0 + 6);
        bs2 = c0;
        be2 = c0 + 6;
    endtask

    task automatic push8(input int c0, input int nfeed, input bit fin);
        clrq8.push_back(c0);
        for (int t = 0; t < nfeed; t++) begin
            feed_t e;
            e.cyc = c0 + 1 + t;
            e.w   = '0;
            e.n   = '0;
            for (int l = 0; l < 8; l++) begin
                if (t >= l && t - l <= 7) begin
                    e.w[l*4 +: 4] = 4'(ea8[l][t-l]);
                    e.n[l*4 +: 4] = 4'(eb8[t-l][l]);
                end
            end
            fq8.push_back(e);
        end
        if (fin) finq8.push_back(c0 + 24);
        bs8 = c0;
        be8 = c0 + 24;
    endtask

    task automatic set_ab2();
        a2[0][0] = 4'd1; a2[0][1] = 4'd2; a2[1][0] = 4'd3; a2[1][1] = 4'd4;
        b2[0][0] = 4'd5; b2[0][1] = 4'd6; b2[1][0] = 4'd7; b2[1][1] = 4'd8;
    endtask

    task automatic load8();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) begin
                a8[i][k] = 4'(ea8[i][k]);
                b8[i][k] = 4'(eb8[i][k]);
            end
        end
    endtask

    // Called just after a rising edge; returns after the accepting edge.
    task automatic accept2(output int c0);
        int n = 0;
        v2 = 1'b1;
        while (rdy2 !== 1'b1 && n < 40) begin @(posedge clk); #2; n++; end
        chk("accept2_ready", 32'(rdy2), 32'd1);
        c0 = cyc + 1;
        push2(c0);
        @(posedge clk); #2;
        v2 = 1'b0;
    endtask

    task automatic accept8(output int c0, input int nfeed, input bit fin);
        int n = 0;
        v8 = 1'b1;
        while (rdy8 !== 1'b1 && n < 60) begin @(posedge clk); #2; n++; end
        chk("accept8_ready", 32'(rdy8), 32'd1);
        c0 = cyc + 1;
        push8(c0, nfeed, fin);
        @(posedge clk); #2;
        v8 = 1'b0;
    endtask

    initial begin
        int c0, nacc, last;
        rst2 = 1'b1; rst8 = 1'b1; v2 = 1'b0; v8 = 1'b0;
        a2 = '0; b2 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #2;
        rst2 = 1'b0; rst8 = 1'b0;
        @(posedge clk); #2;

        // Directed DIM=2 job.
        set_ab2();
        accept2(c0);
        repeat (8) begin @(posedge clk); #2; end

        // Inputs scrambled and in_valid high while busy must not leak in.
        accept2(c0);
        for (int k = 0; k < 7; k++) begin
            v2 = 1'b1;
            a2 = 16'($urandom);
            b2 = 16'($urandom);
            @(posedge clk); #2;
        end
        v2 = 1'b0;
        set_ab2();
        repeat (3) begin @(posedge clk); #2; end

        // in_valid held for 20 cycles: three accepts, 8 cycles apart.
        nacc = 0;
        last = 0;
        v2 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (rdy2 === 1'b1) begin
                nacc++;
                if (nacc > 1) chk("accept_spacing", cyc + 1 - last, 32'd8);
                last = cyc + 1;
                push2(last);
            end
            @(posedge clk); #2;
        end
        v2 = 1'b0;
        chk("accept_count", nacc, 32'd3);
        repeat (10) begin @(posedge clk); #2; end

        // DIM=8: reset during FEED t=1 aborts the job.
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin ea8[i][k] = 7; eb8[i][k] = 9; end
        load8();
        accept8(c0, 2, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst8 = 1'b1;
        be8 = cyc;
        @(posedge clk); #2;
        rst8 = 1'b0;
        chk("rst_rdy8", 32'(rdy8), 32'd1);
        chk("rst_west8", 32'(w8), 32'd0);
        chk("rst_north8", 32'(n8), 32'd0);
        repeat (30) begin @(posedge clk); #2; end

        // All-ones operands: windows only, finished 24 edges after accept.
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin ea8[i][k] = 15; eb8[i][k] = 15; end
        load8();
        accept8(c0, 15, 1'b1);
        repeat (26) begin @(posedge clk); #2; end

        // Index-dependent operands to expose row/column mixups.
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                ea8[i][k] = (i * 3 + k + 1) % 16;
                eb8[i][k] = (i * 5 + k + 2) % 16;
            end
        load8();
        accept8(c0, 15, 1'b1);
        for (int k = 0; k < 26; k++) begin
            a8 = 256'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            @(posedge clk); #2;
        end

        chk("fq2_left", fq2.size(), 32'd0);
        chk("fq8_left", fq8.size(), 32'd0);
        chk("clrq2_left", clrq2.size(), 32'd0);
        chk("clrq8_left", clrq8.size(), 32'd0);
        chk("finq2_left", finq2.size(), 32'd0);
        chk("finq8_left", finq8.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
